// File: rtl/test_pattern_generator.sv
// Test-pattern generator: turns raw video timing plus a pattern index into
// 24-bit RGB pixels, re-aligned to the timing with a one-cycle delay.
module test_pattern_generator #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int BAR_STEP = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  pattern,
    input  logic        in_de,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic        out_de,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic [23:0] out_rgb,
    output logic [3:0]  active_pattern
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int BW = $clog2(H_ACTIVE / 8);

    localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] SEG_MAX = BW'(H_ACTIVE / 8 - 1);
    localparam logic [XW:0]   POS_LIM = (XW+1)'(H_ACTIVE - 16);
    localparam logic [XW:0]   STEP    = (XW+1)'(BAR_STEP);
    localparam logic [XW:0]   BAR_W   = (XW+1)'(15);
    localparam logic [15:0]   SEED    = 16'hACE1;
    localparam logic [23:0]   WHITE   = 24'hFFFFFF;

    logic [XW-1:0] x, x_e;
    logic [YW-1:0] y, y_e;
    logic [BW-1:0] bar_cnt, bcnt_e;
    logic [2:0]    bar_idx, bidx_e;
    logic [XW-1:0] pos, pos_e, pos_new;
    logic [XW:0]   pos_adv, pos_end;
    logic [15:0]   lfsr, lfsr_e, lfsr_nx;
    logic [7:0]    xl, yl;
    logic [3:0]    pat_e;
    logic [23:0]   pix, bar_rgb;
    logic          vsync_prev;
    logic          fs, eol, bar_hit;

    // On a frame-start cycle the pixel itself already sees the new frame.
    always_comb begin
        fs      = in_vsync & ~vsync_prev;
        eol     = ~in_de & out_de;
        pos_adv = {1'b0, pos} + STEP;
        pos_new = (pos_adv > POS_LIM) ? '0 : pos_adv[XW-1:0];
        x_e     = fs ? '0 : x;
        y_e     = fs ? '0 : y;
        bcnt_e  = fs ? '0 : bar_cnt;
        bidx_e  = fs ? '0 : bar_idx;
        pos_e   = fs ? pos_new : pos;
        lfsr_e  = fs ? SEED : lfsr;
        pat_e   = fs ? pattern : active_pattern;
        lfsr_nx = {lfsr_e[14:0],
                   lfsr_e[15] ^ lfsr_e[13] ^ lfsr_e[12] ^ lfsr_e[10]};
        xl      = 8'(x_e);
        yl      = 8'(y_e);
        pos_end = {1'b0, pos_e} + BAR_W;
        bar_hit = (x_e >= pos_e) && ({1'b0, x_e} <= pos_end);
    end

    always_comb begin
        bar_rgb = '0;
        case (bidx_e)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            3'd7: bar_rgb = 24'h000000;
            default: bar_rgb = '0;
        endcase
    end

    always_comb begin
        pix = '0;
        case (pat_e)
            4'd1: pix = WHITE;
            4'd2: pix = bar_rgb;
            4'd3: pix = {xl, xl, xl};
            4'd4: pix = (xl[5] ^ yl[5]) ? WHITE : '0;
            4'd5: pix = (xl[5:0] == 6'd0 || yl[5:0] == 6'd0 ||
                         x_e == X_MAX || y_e == Y_MAX) ? WHITE : '0;
            4'd6: pix = bar_hit ? WHITE : '0;
            4'd7: pix = {8'h00, yl, 8'h00};
            4'd8: pix = {lfsr_e[15:8], lfsr_e[7:0], lfsr_e[15:8]};
            default: pix = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_de         <= 1'b0;
            out_hsync      <= 1'b0;
            out_vsync      <= 1'b0;
            out_rgb        <= '0;
            active_pattern <= 4'd4;
            vsync_prev     <= 1'b0;
            x              <= '0;
            y              <= '0;
            bar_cnt        <= '0;
            bar_idx        <= '0;
            pos            <= '0;
            lfsr           <= SEED;
        end else begin
            out_de     <= in_de;
            out_hsync  <= in_hsync;
            out_vsync  <= in_vsync;
            out_rgb    <= in_de ? pix : '0;
            vsync_prev <= in_vsync;

            if (fs) begin
                active_pattern <= pattern;
                pos            <= pos_new;
            end

            if (fs)
                y <= '0;
            else if (eol && y != Y_MAX)
                y <= y + 1'b1;

            // Bar index tracks x*8/H_ACTIVE via a per-segment counter.
            if (in_de) begin
                x <= (x_e == X_MAX) ? x_e : x_e + 1'b1;
                if (bcnt_e == SEG_MAX) begin
                    bar_cnt <= '0;
                    bar_idx <= (bidx_e == 3'd7) ? bidx_e : bidx_e + 1'b1;
                end else begin
                    bar_cnt <= bcnt_e + 1'b1;
                    bar_idx <= bidx_e;
                end
            end else if (fs || eol) begin
                x       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
            end

            if (in_de)
                lfsr <= lfsr_nx;
            else if (fs)
                lfsr <= SEED;
        end
    end

endmodule

// File: tb/tb_test_pattern_generator.sv
// Self-checking bench for test_pattern_generator: a reference model pushes
// expected outputs per driven cycle; each scenario drains and compares.
module tb_test_pattern_generator;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  pattern = 4'd0;
    logic        in_de = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        out_de, out_hsync, out_vsync;
    logic [23:0] out_rgb;
    logic [3:0]  active_pattern;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        logic [3:0]  ap;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int checks = 0;
    int failures = 0;

    int          m_x, m_y, m_pos;
    logic [3:0]  m_pat;
    logic [15:0] m_lfsr;
    logic        m_vprev, m_deprev;
    logic [23:0] last_rgb;
    logic [3:0]  last_ap;

    always #5 clk = ~clk;

    test_pattern_generator dut (
        .clk(clk),
        .resetn(resetn),
        .pattern(pattern),
        .in_de(in_de),
        .in_hsync(in_hsync),
        .in_vsync(in_vsync),
        .out_de(out_de),
        .out_hsync(out_hsync),
        .out_vsync(out_vsync),
        .out_rgb(out_rgb),
        .active_pattern(active_pattern)
    );

    task automatic model_reset();
        m_x = 0; m_y = 0; m_pos = 0;
        m_pat = 4'd4; m_lfsr = 16'hACE1;
        m_vprev = 1'b0; m_deprev = 1'b0;
    endtask

    function automatic logic [23:0] ref_pix(input logic [3:0] pat,
                                            input int x, input int y,
                                            input int pos,
                                            input logic [15:0] l);
        logic [23:0] r;
        logic [7:0] g;
        r = 24'h0;
        case (pat)
            4'd1: r = 24'hFFFFFF;
            4'd2: case (x * 8 / 1280)
                      0: r = 24'hFFFFFF;
                      1: r = 24'hFFFF00;
                      2: r = 24'h00FFFF;
                      3: r = 24'h00FF00;
                      4: r = 24'hFF00FF;
                      5: r = 24'hFF0000;
                      6: r = 24'h0000FF;
                      default: r = 24'h000000;
                  endcase
            4'd3: begin g = 8'(x); r = {g, g, g}; end
            4'd4: r = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            4'd5: r = (x % 64 == 0 || y % 64 == 0 || x == 1279 || y == 719)
                      ? 24'hFFFFFF : 24'h0;
            4'd6: r = (x >= pos && x <= pos + 15) ? 24'hFFFFFF : 24'h0;
            4'd7: begin g = 8'(y); r = {8'h00, g, 8'h00}; end
            4'd8: r = {l[15:8], l[7:0], l[15:8]};
            default: r = 24'h0;
        endcase
        return r;
    endfunction

    task automatic cyc(input logic de, input logic hs, input logic vs,
                       input logic [3:0] p);
        obs_t e, o;
        in_de = de; in_hsync = hs; in_vsync = vs; pattern = p;
        if (vs && !m_vprev) begin
            m_pat = p; m_x = 0; m_y = 0; m_lfsr = 16'hACE1;
            m_pos = (m_pos + 4 > 1264) ? 0 : m_pos + 4;
        end else if (!de && m_deprev) begin
            m_x = 0;
            if (m_y < 719) m_y++;
        end
        e.de = de; e.hs = hs; e.vs = vs; e.ap = m_pat;
        e.rgb = de ? ref_pix(m_pat, m_x, m_y, m_pos, m_lfsr) : 24'h0;
        if (de) begin
            if (m_x < 1279) m_x++;
            m_lfsr = {m_lfsr[14:0],
                      m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        m_vprev = vs; m_deprev = de;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.de = out_de; o.hs = out_hsync; o.vs = out_vsync;
        o.rgb = out_rgb; o.ap = active_pattern;
        obs_q.push_back(o);
        last_rgb = out_rgb;
        last_ap = active_pattern;
    endtask

    task automatic vsync_pulse(input logic [3:0] p);
        cyc(1'b0, 1'b0, 1'b1, p);
        cyc(1'b0, 1'b0, 1'b1, p);
        cyc(1'b0, 1'b0, 1'b0, p);
        cyc(1'b0, 1'b0, 1'b0, p);
    endtask

    task automatic gap(input logic [3:0] p);
        cyc(1'b0, 1'b1, 1'b0, p);
        cyc(1'b0, 1'b1, 1'b0, p);
        cyc(1'b0, 1'b0, 1'b0, p);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        in_de = 1'b1; in_hsync = 1'b1; in_vsync = 1'b1; pattern = 4'd2;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_de, out_hsync, out_vsync, out_rgb} !== 27'd0 ||
                active_pattern !== 4'd4) begin
                failures++;
                $display("FAIL reset got de%b hs%b vs%b rgb=%h ap=%h want zeros ap=4",
                         out_de, out_hsync, out_vsync, out_rgb, active_pattern);
            end
        end
        in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_bars();
        obs_t e, o;
        logic [23:0] want;
        for (int x = 0; x < 1280; x++) cyc(1'b1, 1'b0, 1'b0, 4'd2);
        checks++;
        if (last_ap !== 4'd4) begin
            failures++;
            $display("FAIL bars_first_frame_ap got=%h want=4", last_ap);
        end
        gap(4'd2);
        vsync_pulse(4'd2);
        checks++;
        if (last_ap !== 4'd2) begin
            failures++;
            $display("FAIL bars_ap got=%h want=2", last_ap);
        end
        for (int x = 0; x < 1280; x++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd2);
            if (x == 0 || x == 160 || x == 320 || x == 1279) begin
                want = (x == 0) ? 24'hFFFFFF : (x == 160) ? 24'hFFFF00 :
                       (x == 320) ? 24'h00FFFF : 24'h000000;
                checks++;
                if (last_rgb !== want) begin
                    failures++;
                    $display("FAIL bars_x%0d got=%h want=%h", x, last_rgb, want);
                end
            end
        end
        gap(4'd2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bars_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_pattern_hold();
        obs_t e, o;
        logic [3:0] p;
        vsync_pulse(4'd1);
        for (int ln = 0; ln < 302; ln++) begin
            p = (ln < 300) ? 4'd1 : 4'd0;
            for (int x = 0; x < 8; x++) cyc(1'b1, 1'b0, 1'b0, p);
            if (ln == 301) begin
                checks++;
                if (last_rgb !== 24'hFFFFFF) begin
                    failures++;
                    $display("FAIL hold_after_change got=%h want=ffffff", last_rgb);
                end
            end
            gap(p);
        end
        vsync_pulse(4'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (last_rgb !== 24'h000000) begin
            failures++;
            $display("FAIL hold_new_frame got=%h want=000000", last_rgb);
        end
        gap(4'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hold_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_ramp_checker();
        obs_t e, o;
        logic [23:0] want;
        vsync_pulse(4'd3);
        for (int x = 0; x < 1290; x++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd3);
            if (x == 0 || x == 127 || x == 255 || x == 256 || x == 1289) begin
                want = (x == 127) ? 24'h7F7F7F :
                       (x == 255 || x == 1289) ? 24'hFFFFFF : 24'h000000;
                checks++;
                if (last_rgb !== want) begin
                    failures++;
                    $display("FAIL hramp_x%0d got=%h want=%h", x, last_rgb, want);
                end
            end
        end
        gap(4'd3);
        vsync_pulse(4'd4);
        for (int ln = 0; ln < 33; ln++) begin
            for (int x = 0; x < 40; x++) begin
                cyc(1'b1, 1'b0, 1'b0, 4'd4);
                if (x == 32 && (ln == 0 || ln == 32)) begin
                    want = (ln == 0) ? 24'hFFFFFF : 24'h000000;
                    checks++;
                    if (last_rgb !== want) begin
                        failures++;
                        $display("FAIL checker_y%0d got=%h want=%h", ln, last_rgb, want);
                    end
                end
            end
            gap(4'd4);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ramp_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_grid_vramp();
        obs_t e, o;
        logic [23:0] want;
        vsync_pulse(4'd5);
        cyc(1'b1, 1'b0, 1'b0, 4'd5);
        cyc(1'b1, 1'b0, 1'b0, 4'd5);
        checks++;
        if (last_rgb !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL grid_row0 got=%h want=ffffff", last_rgb);
        end
        gap(4'd5);
        for (int x = 0; x < 1280; x++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd5);
            if (x == 0 || x == 1 || x == 64 || x == 1279) begin
                want = (x == 1) ? 24'h000000 : 24'hFFFFFF;
                checks++;
                if (last_rgb !== want) begin
                    failures++;
                    $display("FAIL grid_x%0d got=%h want=%h", x, last_rgb, want);
                end
            end
        end
        gap(4'd5);
        vsync_pulse(4'd7);
        for (int ln = 0; ln < 721; ln++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd7);
            cyc(1'b1, 1'b0, 1'b0, 4'd7);
            if (ln == 1 || ln == 719 || ln == 720) begin
                want = (ln == 1) ? 24'h000100 : 24'h00CF00;
                checks++;
                if (last_rgb !== want) begin
                    failures++;
                    $display("FAIL vramp_line%0d got=%h want=%h", ln, last_rgb, want);
                end
            end
            cyc(1'b0, 1'b1, 1'b0, 4'd7);
            cyc(1'b0, 1'b0, 1'b0, 4'd7);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL grid_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_moving_bar();
        obs_t e, o;
        int first, want;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        for (int f = 1; f <= 322; f++) begin
            vsync_pulse(4'd6);
            if (f inside {1, 2, 3, 316, 317, 318, 322}) begin
                first = -1;
                for (int x = 0; x < 1280; x++) begin
                    cyc(1'b1, 1'b0, 1'b0, 4'd6);
                    if (first < 0 && last_rgb == 24'hFFFFFF) first = x;
                end
                gap(4'd6);
                want = (f <= 316) ? 4 * f : 4 * (f - 317);
                checks++;
                if (first != want) begin
                    failures++;
                    $display("FAIL bar_frame%0d got=%0d want=%0d", f, first, want);
                end
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bar_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_noise();
        obs_t e, o;
        logic [23:0] seq [40];
        for (int fr = 0; fr < 2; fr++) begin
            vsync_pulse(4'd8);
            for (int i = 0; i < 40; i++) begin
                if (i == 20) repeat (5) cyc(1'b0, 1'b0, 1'b0, 4'd8);
                cyc(1'b1, 1'b0, 1'b0, 4'd8);
                if (fr == 0) begin
                    seq[i] = last_rgb;
                    if (i < 2) begin
                        checks++;
                        if (last_rgb !== ((i == 0) ? 24'hACE1AC : 24'h59C359)) begin
                            failures++;
                            $display("FAIL noise_px%0d got=%h", i, last_rgb);
                        end
                    end
                end else begin
                    checks++;
                    if (last_rgb !== seq[i]) begin
                        failures++;
                        $display("FAIL noise_repeat_px%0d got=%h want=%h",
                                 i, last_rgb, seq[i]);
                    end
                end
            end
            gap(4'd8);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL noise_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_degenerate();
        obs_t e, o;
        cyc(1'b0, 1'b0, 1'b0, 4'd3);
        cyc(1'b1, 1'b0, 1'b1, 4'd3);
        checks++;
        if (last_rgb !== 24'h000000 || last_ap !== 4'd3) begin
            failures++;
            $display("FAIL degen_first got=%h ap=%h want=000000 ap=3", last_rgb, last_ap);
        end
        cyc(1'b1, 1'b0, 1'b1, 4'd3);
        checks++;
        if (last_rgb !== 24'h010101) begin
            failures++;
            $display("FAIL degen_second got=%h want=010101", last_rgb);
        end
        cyc(1'b1, 1'b0, 1'b0, 4'd3);
        gap(4'd3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL degen_sb got=%h want=%h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        logic [23:0] want;
        vsync_pulse(4'd1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 4'd1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midreset_pre_sb got=%h want=%h", o, e);
            end
        end
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_de, out_hsync, out_vsync, out_rgb} !== 27'd0 ||
                active_pattern !== 4'd4) begin
                failures++;
                $display("FAIL midreset_hold%0d got de%b rgb=%h ap=%h want zeros ap=4",
                         i, out_de, out_rgb, active_pattern);
            end
            in_de = ~in_de; in_hsync = ~in_hsync;
            @(posedge clk);
            #1;
        end
        in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        resetn = 1'b1;
        model_reset();
        for (int ln = 0; ln < 2; ln++) begin
            for (int x = 0; x < 64; x++) begin
                cyc(1'b1, 1'b0, 1'b0, 4'd1);
                if (ln == 0 && (x == 0 || x == 32)) begin
                    want = (x == 32) ? 24'hFFFFFF : 24'h000000;
                    checks++;
                    if (last_rgb !== want) begin
                        failures++;
                        $display("FAIL midreset_pat4_x%0d got=%h want=%h",
                                 x, last_rgb, want);
                    end
                end
            end
            gap(4'd1);
        end
        vsync_pulse(4'd9);
        cyc(1'b1, 1'b0, 1'b0, 4'd9);
        checks++;
        if (last_rgb !== 24'h000000 || last_ap !== 4'd9) begin
            failures++;
            $display("FAIL midreset_pat9 got=%h ap=%h want=000000 ap=9", last_rgb, last_ap);
        end
        gap(4'd9);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midreset_sb got=%h want=%h", o, e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bars();
        test_pattern_hold();
        test_ramp_checker();
        test_grid_vramp();
        test_moving_bar();
        test_noise();
        test_degenerate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_pattern_generator.md
Name: test_pattern_generator

Overview:
Sits directly downstream of pattern_selector. Consumes its 4-bit grid index (0-8) plus raw video timing from the timing generator, and produces 24-bit RGB test-pattern pixels with matching delayed timing. Pattern changes take effect only at frame start, so the image never tears.

Parameters:
H_ACTIVE, 1280, active pixels per line; must be a multiple of 8 and at least 64.
V_ACTIVE, 720, active lines per frame.
BAR_STEP, 4, pixels per frame that the moving bar (pattern 6) advances.

Ports:
clk  input  1  pixel clock
resetn  input  1  asynchronous active-low reset
pattern  input  4  requested pattern index from pattern_selector
in_de  input  1  data enable, high during active pixels
in_hsync  input  1  horizontal sync, passed through
in_vsync  input  1  vertical sync, active-high; rising edge marks frame start
out_de  output  1  in_de delayed one cycle
out_hsync  output  1  in_hsync delayed one cycle
out_vsync  output  1  in_vsync delayed one cycle
out_rgb  output  24  pixel {R[23:16],G[15:8],B[7:0]}; 0 when out_de low
active_pattern  output  4  pattern currently being rendered

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on resetn.
- Reset values: out_de, out_hsync, out_vsync = 0; out_rgb = 0; active_pattern = 4; x, y, frame counter, bar position = 0; LFSR = 16'hACE1; registered vsync_prev = 0.
- Latency: exactly 1 cycle from input timing to output timing and RGB. All outputs are registered.
- Frame start means in_vsync = 1 and vsync_prev = 0. On that cycle:
  - active_pattern <= pattern.
  - y <= 0.
  - LFSR <= 16'hACE1.
  - bar position advances by BAR_STEP; it wraps to 0 when the new position + 16 would exceed H_ACTIVE.
- pattern is ignored at all other times.
- x: pixel index of the current in_de cycle. It starts at 0 and increments after each de cycle, saturating at H_ACTIVE-1.
- End of line is the falling edge of in_de. On it, x <= 0, and y increments, saturating at V_ACTIVE-1.
- Bar index (0-7) = floor(x*8/H_ACTIVE). Generate it with a boundary counter reloaded at H_ACTIVE/8; no divider.
- Patterns, computed from the current x/y while in_de = 1:
  0: black 000000.
  1: white FFFFFF.
  2: 8 colour bars, in order white, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black.
  3: grey horizontal ramp; R = G = B = x[7:0].
  4: 32x32 checkerboard; white if x[5]^y[5], else black.
  5: grid; white if x[5:0]==0, y[5:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; else black.
  6: moving bar; white if pos <= x <= pos+15, else black.
  7: green vertical ramp; G = y[7:0], R = B = 0.
  8: noise from the LFSR.
     - Fibonacci, shifting left; feedback = l[15]^l[13]^l[12]^l[10].
     - Advances once per in_de cycle, after use.
     - RGB = {l[15:8], l[7:0], l[15:8]}.
  9-15: black.
- Noise (pattern 8) is identical every frame.
- While in_de = 0, out_rgb <= 0. The LFSR, x and bar counters hold.
- Frame start on the same cycle as in_de = 1 (degenerate timing): the frame-start updates take priority. That pixel uses x = 0, y = 0 and the new pattern.
- Timing outputs are a pure one-cycle delay regardless of pattern.
- Reset mid-frame: all state returns to reset values immediately. Lines before the next vsync render with y counting from 0 and pattern 4. Full alignment is restored at the next frame start.
- in_de before any vsync after reset renders pattern 4 with y counted from 0.

Test Plan:
- Reset with resetn = 0, then release; drive one frame with pattern = 2 → active_pattern = 4 during frame 1; after the 2nd vsync rise it is 2, and out_rgb for x = 0, 160, 320, 1279 is FFFFFF, FFFF00, 00FFFF, 000000.
- Change pattern from 1 to 0 mid-frame (line 300) → out_rgb stays FFFFFF through the remaining lines; it is 000000 from the first pixel after the next vsync rise.
- Pattern 3 → out_rgb = 000000 at x = 0, 7F7F7F at x = 127, FFFFFF at x = 255, 000000 at x = 256. Pattern 4 at (x=32, y=0) → FFFFFF; at (32, 32) → 000000.
- Pattern 6 over 322 frames → bar starts at x = 4, 8, 12, ...; it wraps to 0 once pos + 16 > 1280, i.e. on the frame after pos = 1264.
- Pattern 8, two consecutive frames → first pixel RGB = ACE1AC in both; the pixel sequence is identical across frames. Gaps in in_de do not advance the LFSR.
- Reset asserted mid-line, then in_de pulses without vsync → all outputs 0 during reset; out_de follows in_de with 1-cycle delay; pattern 4 is rendered; pattern = 9 after the next vsync → out_rgb = 000000.
